tff_toggle_monitor: RTL and testbench
=====================================

Name: tff_toggle_monitor

Overview:
- Downstream consumer of the T flip-flop: samples the flop's q output together with the t input that drove it.
- Produces registered rise/fall pulses, a saturating toggle count, and a per-cycle mismatch flag when q fails to follow t.
- Enters a sticky FAULT state after ERR_LIMIT mismatches.
- Sits beside the TFF in the top level as on-chip self-check logic; the bench scoreboards against it.

Parameters:
CNT_W, 8, width of toggle_cnt; counter saturates at 2**CNT_W-1
ERR_LIMIT, 3, mismatches (1..255) that move the FSM into FAULT
ERR_W, $clog2(ERR_LIMIT+1), derived local width of mismatch_cnt; not overridable

Ports:
clk  input  1  single clock, all logic on posedge
rstn  input  1  asynchronous active-low reset
enable  input  1  1 = monitor active; 0 = return to IDLE
clear  input  1  synchronous clear of counts, flags and FAULT
t_in  input  1  t value presented to the TFF this cycle
q_in  input  1  TFF q output
rise  output  1  one-cycle pulse: q went 0->1 between consecutive samples
fall  output  1  one-cycle pulse: q went 1->0
mismatch  output  1  one-cycle pulse: (q changed) != (previous-cycle t)
toggle_cnt  output  CNT_W  number of q edges seen since clear/enable, saturating
mismatch_cnt  output  ERR_W  number of mismatches, saturating at ERR_LIMIT
fault  output  1  sticky; high while FSM is in FAULT
state  output  2  current FSM state, encoding from package

Behaviour:
- Reset (rstn=0, async): q_prev=0, t_prev=0; all outputs 0; state=IDLE. Reset asserted mid-operation discards all history. The first posedge after release behaves as an IDLE cycle.
- Sampling: q_in and t_in are sampled every posedge into q_prev and t_prev. The TFF updates q at edge k, so the toggle requested by t at edge k appears as q_in(k+1) != q_prev.
- Derived per edge: chg = q_in ^ q_prev.
- FSM states are IDLE=0, ARMED=1, TRACK=2, FAULT=3.
- IDLE: pulses held 0, counters held. enable=1 -> ARMED.
- ARMED: captures q_prev/t_prev only; no edge reported, no check. -> TRACK.
- TRACK, per edge:
  - rise <= q_in & ~q_prev; fall <= ~q_in & q_prev.
  - toggle_cnt += chg, saturating.
  - mismatch <= chg ^ t_prev; mismatch_cnt += mismatch, saturating at ERR_LIMIT.
  - When mismatch_cnt+1 reaches ERR_LIMIT on a mismatch cycle -> FAULT. fault rises on the same edge as the final mismatch pulse.
- FAULT: rise/fall/toggle_cnt keep updating as in TRACK. mismatch still pulses, but mismatch_cnt is frozen at ERR_LIMIT. fault=1. Leaves FAULT only on clear, enable=0 or reset.
- enable=0 in any state -> IDLE next edge; pulses 0 that cycle; counters retain value.
- clear=1 with enable=1:
  - Counters and pulses go to 0, fault goes to 0, state -> ARMED.
  - clear overrides any increment or mismatch in the same cycle.
- clear=1 with enable=0: counters go to 0, state -> IDLE. Disable has priority over re-arm.
- Leaving IDLE always passes through ARMED, so stale q_prev never produces a false edge.
- Outputs are all registered; latency from the q_in change sample to the rise/fall/mismatch pulse is one clock.
- toggle_cnt holds at all-ones; no wrap.

Decomposition:
- Package tff_mon_pkg: typedef enum logic [1:0] mon_state_e {IDLE, ARMED, TRACK, FAULT}; localparam default CNT_W.
- One sub-module, tff_edge_detect: holds q_prev/t_prev registers and produces combinational chg, rise_c, fall_c, miss_c plus a valid-gate input.
- The top instance contains the FSM, both counters and the output registers.

Test Plan:
- Reset mid-TRACK with toggle_cnt=5 -> all outputs 0 and state=IDLE immediately (async); after release with enable=1, first edge ARMED, no pulses.
- enable=1, t_in=1 for 6 cycles from q=0 -> rise/fall alternate starting one cycle after the first q change; toggle_cnt=6; mismatch never asserts.
- Model drives q constant while t_in=1 for 3 cycles -> mismatch pulses 3 times; mismatch_cnt=1,2,3; fault=1 and state=FAULT on the third pulse.
- Model toggles q with t_in=0 once -> single mismatch pulse; mismatch_cnt=1; state stays TRACK.
- CNT_W=3, 10 toggles -> toggle_cnt stops at 7.
- In FAULT, clear=1 and enable=1 in the same cycle as a q edge -> next cycle counters 0, fault=0, state=ARMED, no rise/fall pulse. Then enable=0 -> IDLE with counts held.

Source files
------------

// File: rtl/tff_mon_pkg.sv
// Shared types and defaults for the T flip-flop toggle monitor.
//   mon_state_e   : monitor FSM state encoding (also driven out on the state port)
//   CNT_W_DEFAULT : default width of the toggle counter
package tff_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    TRACK = 2'd2,
    FAULT = 2'd3
  } mon_state_e;

  localparam int unsigned CNT_W_DEFAULT = 8;

endpackage

// File: rtl/tff_edge_detect.sv
// Sample history and combinational edge/consistency detection for a TFF output.
// Ports:
//   clk, rstn : clock, asynchronous active-low reset
//   valid     : gate; when low all detector outputs are forced to 0
//   t_in      : t value presented to the TFF this cycle
//   q_in      : TFF q output
//   chg       : q changed since the previous sample
//   rise_c    : q went 0->1 since the previous sample
//   fall_c    : q went 1->0 since the previous sample
//   miss_c    : q change disagrees with the t presented one cycle earlier
module tff_edge_detect (
  input  logic clk,
  input  logic rstn,
  input  logic valid,
  input  logic t_in,
  input  logic q_in,
  output logic chg,
  output logic rise_c,
  output logic fall_c,
  output logic miss_c
);

  logic q_prev;
  logic t_prev;

  // History is captured every edge regardless of the gate so that the cycle
  // after arming already compares against a fresh sample.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q_prev <= 1'b0;
      t_prev <= 1'b0;
    end else begin
      q_prev <= q_in;
      t_prev <= t_in;
    end
  end

  assign chg    = valid & (q_in ^ q_prev);
  assign rise_c = valid & q_in & ~q_prev;
  assign fall_c = valid & ~q_in & q_prev;
  // A TFF toggles at edge k iff t was high at edge k, seen here one edge later.
  assign miss_c = valid & ((q_in ^ q_prev) ^ t_prev);

endmodule

// File: rtl/tff_toggle_monitor.sv
// On-chip self-check for a T flip-flop: registered rise/fall pulses, a
// saturating toggle counter, a per-cycle mismatch pulse and a sticky FAULT
// state once ERR_LIMIT mismatches have been seen.
// Ports:
//   clk, rstn    : clock, asynchronous active-low reset
//   enable       : 1 = monitor active, 0 = return to IDLE
//   clear        : synchronous clear of counts, pulses and FAULT
//   t_in, q_in   : t driving the TFF, and the TFF q output
//   rise, fall   : one-cycle registered q edge pulses
//   mismatch     : one-cycle pulse when the q change disagrees with prior t
//   toggle_cnt   : q edges seen, saturating at all-ones
//   mismatch_cnt : mismatches seen, saturating at ERR_LIMIT
//   fault        : high while in FAULT
//   state        : current FSM state (mon_state_e encoding)
module tff_toggle_monitor
  import tff_mon_pkg::*;
#(
  parameter  int unsigned CNT_W     = CNT_W_DEFAULT,
  parameter  int unsigned ERR_LIMIT = 3,
  localparam int unsigned ERR_W     = $clog2(ERR_LIMIT + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enable,
  input  logic             clear,
  input  logic             t_in,
  input  logic             q_in,
  output logic             rise,
  output logic             fall,
  output logic             mismatch,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic [ERR_W-1:0] mismatch_cnt,
  output logic             fault,
  output logic [1:0]       state
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  // Count value at which the next mismatch is the final one.
  localparam logic [ERR_W-1:0] ERR_LAST = ERR_W'(ERR_LIMIT - 1);

  mon_state_e       state_q, state_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             miss_q, miss_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic [ERR_W-1:0] mcnt_q, mcnt_d;

  logic valid;
  logic chg, rise_c, fall_c, miss_c;

  assign valid = (state_q == TRACK) || (state_q == FAULT);

  tff_edge_detect u_edge (
    .clk    (clk),
    .rstn   (rstn),
    .valid  (valid),
    .t_in   (t_in),
    .q_in   (q_in),
    .chg    (chg),
    .rise_c (rise_c),
    .fall_c (fall_c),
    .miss_c (miss_c)
  );

  always_comb begin
    state_d = state_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    miss_d  = 1'b0;
    tcnt_d  = tcnt_q;
    mcnt_d  = mcnt_q;

    if (!enable) begin
      // Disable wins over re-arm; counters are kept unless cleared.
      state_d = IDLE;
      if (clear) begin
        tcnt_d = '0;
        mcnt_d = '0;
      end
    end else if (clear) begin
      state_d = ARMED;
      tcnt_d  = '0;
      mcnt_d  = '0;
    end else begin
      case (state_q)
        IDLE:  state_d = ARMED;
        // ARMED only refreshes the sample history so no stale edge is seen.
        ARMED: state_d = TRACK;
        TRACK, FAULT: begin
          rise_d = rise_c;
          fall_d = fall_c;
          miss_d = miss_c;
          if (chg && (tcnt_q != CNT_MAX)) begin
            tcnt_d = tcnt_q + CNT_W'(1);
          end
          // In FAULT the mismatch count is frozen at ERR_LIMIT.
          if (miss_c && (state_q == TRACK)) begin
            mcnt_d = mcnt_q + ERR_W'(1);
            if (mcnt_q == ERR_LAST) begin
              state_d = FAULT;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      miss_q  <= 1'b0;
      tcnt_q  <= '0;
      mcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      miss_q  <= miss_d;
      tcnt_q  <= tcnt_d;
      mcnt_q  <= mcnt_d;
    end
  end

  assign rise         = rise_q;
  assign fall         = fall_q;
  assign mismatch     = miss_q;
  assign toggle_cnt   = tcnt_q;
  assign mismatch_cnt = mcnt_q;
  assign fault        = (state_q == FAULT);
  assign state        = state_q;

endmodule

// File: tb/tb_tff_toggle_monitor.sv
// Scoreboard bench for tff_toggle_monitor: a bench-side TFF drives q_in (with
// optional stuck/spurious-flip corruption), a cycle model predicts every output
// and pushes it into a queue, and the queue is popped after each clock edge.
module tb_tff_toggle_monitor;

  localparam int ERR_LIMIT = 3;
  localparam int ST_IDLE = 0, ST_ARMED = 1, ST_TRACK = 2, ST_FAULT = 3;
  localparam int M_NORMAL = 0, M_STUCK = 1, M_FLIP = 2;

  logic clk = 1'b0;
  logic rstn, enable, clear, t_in, q_in;

  logic       rise, fall, mismatch, fault;
  logic [7:0] toggle_cnt;
  logic [1:0] mismatch_cnt, state;

  logic       rise3, fall3, mismatch3, fault3;
  logic [2:0] toggle_cnt3;
  logic [1:0] mismatch_cnt3, state3;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       rise;
    logic       fall;
    logic       miss;
    logic [7:0] tcnt;
    logic [1:0] mcnt;
    logic       fault;
    logic [1:0] state;
    logic [2:0] tcnt3;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state.
  logic m_qprev, m_tprev;
  int   m_state, m_tcnt, m_tcnt3, m_mcnt;

  always #5 clk = ~clk;

  tff_toggle_monitor dut (
    .clk          (clk),
    .rstn         (rstn),
    .enable       (enable),
    .clear        (clear),
    .t_in         (t_in),
    .q_in         (q_in),
    .rise         (rise),
    .fall         (fall),
    .mismatch     (mismatch),
    .toggle_cnt   (toggle_cnt),
    .mismatch_cnt (mismatch_cnt),
    .fault        (fault),
    .state        (state)
  );

  tff_toggle_monitor #(.CNT_W(3)) dut3 (
    .clk          (clk),
    .rstn         (rstn),
    .enable       (enable),
    .clear        (clear),
    .t_in         (t_in),
    .q_in         (q_in),
    .rise         (rise3),
    .fall         (fall3),
    .mismatch     (mismatch3),
    .toggle_cnt   (toggle_cnt3),
    .mismatch_cnt (mismatch_cnt3),
    .fault        (fault3),
    .state        (state3)
  );

  task automatic model_reset();
    m_qprev = 1'b0;
    m_tprev = 1'b0;
    m_state = ST_IDLE;
    m_tcnt  = 0;
    m_tcnt3 = 0;
    m_mcnt  = 0;
    exp_q.delete();
  endtask

  // One clock: drive inputs, predict, clock, advance the TFF, pop and compare.
  task automatic step(input logic en, input logic clr, input logic t, input int mode);
    exp_t e, got;
    logic chg, n_rise, n_fall, n_miss;
    int   ns;
    enable = en;
    clear  = clr;
    t_in   = t;

    chg    = q_in ^ m_qprev;
    n_rise = 1'b0;
    n_fall = 1'b0;
    n_miss = 1'b0;
    ns     = m_state;
    if (!en) begin
      ns = ST_IDLE;
      if (clr) begin
        m_tcnt = 0; m_tcnt3 = 0; m_mcnt = 0;
      end
    end else if (clr) begin
      ns = ST_ARMED;
      m_tcnt = 0; m_tcnt3 = 0; m_mcnt = 0;
    end else if (m_state == ST_IDLE) begin
      ns = ST_ARMED;
    end else if (m_state == ST_ARMED) begin
      ns = ST_TRACK;
    end else begin
      n_rise = q_in & ~m_qprev;
      n_fall = ~q_in & m_qprev;
      n_miss = chg ^ m_tprev;
      if (chg) begin
        if (m_tcnt < 255) m_tcnt++;
        if (m_tcnt3 < 7) m_tcnt3++;
      end
      if (n_miss && m_state == ST_TRACK) begin
        m_mcnt++;
        if (m_mcnt == ERR_LIMIT) ns = ST_FAULT;
      end
    end
    m_state = ns;
    m_qprev = q_in;
    m_tprev = t;

    e.rise  = n_rise;
    e.fall  = n_fall;
    e.miss  = n_miss;
    e.tcnt  = 8'(m_tcnt);
    e.mcnt  = 2'(m_mcnt);
    e.fault = (m_state == ST_FAULT);
    e.state = 2'(m_state);
    e.tcnt3 = 3'(m_tcnt3);
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    case (mode)
      M_STUCK: q_in = q_in;
      M_FLIP:  q_in = ~q_in;
      default: q_in = q_in ^ t;
    endcase

    got = {rise, fall, mismatch, toggle_cnt, mismatch_cnt, fault, state, toggle_cnt3};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: no expected entry at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        errors++;
        $display("FAIL scoreboard @%0t: got r=%b f=%b m=%b tc=%0d mc=%0d flt=%b st=%0d tc3=%0d, exp r=%b f=%b m=%b tc=%0d mc=%0d flt=%b st=%0d tc3=%0d",
                 $time, got.rise, got.fall, got.miss, got.tcnt, got.mcnt, got.fault,
                 got.state, got.tcnt3, e.rise, e.fall, e.miss, e.tcnt, e.mcnt, e.fault,
                 e.state, e.tcnt3);
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; enable = 1'b0; clear = 1'b0; t_in = 1'b0; q_in = 1'b0;
    model_reset();
    #3;
    checks++;
    if ({rise, fall, mismatch, toggle_cnt, mismatch_cnt, fault, state} !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: got tc=%0d mc=%0d st=%0d r=%b f=%b m=%b flt=%b, exp all 0",
               toggle_cnt, mismatch_cnt, state, rise, fall, mismatch, fault);
    end
    @(negedge clk);
    rstn = 1'b1;
    step(1'b0, 1'b0, 1'b0, M_NORMAL);
  endtask

  task automatic test_toggle_run();
    step(1'b1, 1'b0, 1'b0, M_NORMAL);  // IDLE -> ARMED
    step(1'b1, 1'b0, 1'b0, M_NORMAL);  // ARMED -> TRACK
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, M_NORMAL);
    step(1'b1, 1'b0, 1'b0, M_NORMAL);
    checks++;
    if (toggle_cnt !== 8'd6) begin
      errors++; $display("FAIL run_toggle_cnt: got %0d exp 6", toggle_cnt);
    end
    checks++;
    if (mismatch_cnt !== 2'd0) begin
      errors++; $display("FAIL run_mismatch_cnt: got %0d exp 0", mismatch_cnt);
    end
    checks++;
    if (fall !== 1'b1) begin
      errors++; $display("FAIL run_last_fall: got %b exp 1", fall);
    end
    checks++;
    if (state !== 2'(ST_TRACK)) begin
      errors++; $display("FAIL run_state: got %0d exp %0d", state, ST_TRACK);
    end
  endtask

  task automatic test_single_miss();
    step(1'b1, 1'b0, 1'b0, M_FLIP);    // q toggles although t=0
    step(1'b1, 1'b0, 1'b0, M_NORMAL);
    checks++;
    if (mismatch !== 1'b1) begin
      errors++; $display("FAIL single_miss_pulse: got %b exp 1", mismatch);
    end
    checks++;
    if (mismatch_cnt !== 2'd1) begin
      errors++; $display("FAIL single_miss_cnt: got %0d exp 1", mismatch_cnt);
    end
    checks++;
    if (state !== 2'(ST_TRACK)) begin
      errors++; $display("FAIL single_miss_state: got %0d exp %0d", state, ST_TRACK);
    end
    step(1'b1, 1'b0, 1'b0, M_NORMAL);
    checks++;
    if (mismatch !== 1'b0) begin
      errors++; $display("FAIL single_miss_once: got %b exp 0", mismatch);
    end
  endtask

  task automatic test_saturate();
    step(1'b1, 1'b1, 1'b0, M_NORMAL);  // clear -> ARMED
    step(1'b1, 1'b0, 1'b0, M_NORMAL);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1, M_NORMAL);
    step(1'b1, 1'b0, 1'b0, M_NORMAL);
    checks++;
    if (toggle_cnt3 !== 3'd7) begin
      errors++; $display("FAIL sat_cnt3: got %0d exp 7", toggle_cnt3);
    end
    checks++;
    if (toggle_cnt !== 8'd10) begin
      errors++; $display("FAIL sat_cnt8: got %0d exp 10", toggle_cnt);
    end
    checks++;
    if (mismatch_cnt !== 2'd0) begin
      errors++; $display("FAIL sat_cleared_mcnt: got %0d exp 0", mismatch_cnt);
    end
  endtask

  task automatic test_fault();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, M_STUCK);
    step(1'b1, 1'b0, 1'b0, M_NORMAL);  // third mismatch lands here
    checks++;
    if (mismatch !== 1'b1) begin
      errors++; $display("FAIL fault_pulse: got %b exp 1", mismatch);
    end
    checks++;
    if (mismatch_cnt !== 2'd3) begin
      errors++; $display("FAIL fault_mcnt: got %0d exp 3", mismatch_cnt);
    end
    checks++;
    if (fault !== 1'b1) begin
      errors++; $display("FAIL fault_flag: got %b exp 1", fault);
    end
    checks++;
    if (state !== 2'(ST_FAULT)) begin
      errors++; $display("FAIL fault_state: got %0d exp %0d", state, ST_FAULT);
    end
    step(1'b1, 1'b0, 1'b1, M_STUCK);
    step(1'b1, 1'b0, 1'b0, M_NORMAL);
    checks++;
    if (mismatch !== 1'b1) begin
      errors++; $display("FAIL fault_still_pulses: got %b exp 1", mismatch);
    end
    checks++;
    if (mismatch_cnt !== 2'd3) begin
      errors++; $display("FAIL fault_mcnt_frozen: got %0d exp 3", mismatch_cnt);
    end
  endtask

  task automatic test_clear_in_fault();
    step(1'b1, 1'b0, 1'b1, M_NORMAL);  // q toggles: edge seen next cycle
    step(1'b1, 1'b1, 1'b0, M_NORMAL);  // clear in the same cycle as the edge
    checks++;
    if (toggle_cnt !== 8'd0 || mismatch_cnt !== 2'd0) begin
      errors++; $display("FAIL clr_counts: got tc=%0d mc=%0d exp 0 0", toggle_cnt, mismatch_cnt);
    end
    checks++;
    if (fault !== 1'b0) begin
      errors++; $display("FAIL clr_fault: got %b exp 0", fault);
    end
    checks++;
    if (state !== 2'(ST_ARMED)) begin
      errors++; $display("FAIL clr_state: got %0d exp %0d", state, ST_ARMED);
    end
    checks++;
    if ({rise, fall} !== 2'b00) begin
      errors++; $display("FAIL clr_no_edge: got rise=%b fall=%b exp 0 0", rise, fall);
    end
    step(1'b1, 1'b0, 1'b1, M_NORMAL);
    step(1'b1, 1'b0, 1'b1, M_NORMAL);
    step(1'b1, 1'b0, 1'b0, M_NORMAL);
    step(1'b0, 1'b0, 1'b1, M_NORMAL);  // disable
    step(1'b0, 1'b0, 1'b0, M_NORMAL);  // q edge while idle
    checks++;
    if (state !== 2'(ST_IDLE)) begin
      errors++; $display("FAIL dis_state: got %0d exp %0d", state, ST_IDLE);
    end
    checks++;
    if (toggle_cnt !== 8'd2) begin
      errors++; $display("FAIL dis_hold_cnt: got %0d exp 2", toggle_cnt);
    end
    checks++;
    if ({rise, fall, mismatch} !== 3'b000) begin
      errors++; $display("FAIL dis_no_pulse: got r=%b f=%b m=%b exp 0", rise, fall, mismatch);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b0, 1'b0, M_NORMAL);
    step(1'b1, 1'b0, 1'b0, M_NORMAL);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, M_NORMAL);
    step(1'b1, 1'b0, 1'b0, M_NORMAL);
    checks++;
    if (toggle_cnt !== 8'd5 || state !== 2'(ST_TRACK)) begin
      errors++; $display("FAIL mid_pre: got tc=%0d st=%0d exp 5 %0d", toggle_cnt, state, ST_TRACK);
    end
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if ({rise, fall, mismatch, toggle_cnt, mismatch_cnt, fault, state, toggle_cnt3} !== 19'h0) begin
      errors++;
      $display("FAIL mid_async_reset: got tc=%0d mc=%0d st=%0d flt=%b tc3=%0d exp all 0",
               toggle_cnt, mismatch_cnt, state, fault, toggle_cnt3);
    end
    model_reset();
    #2;
    rstn = 1'b1;
    step(1'b1, 1'b0, 1'b1, M_NORMAL);
    checks++;
    if (state !== 2'(ST_ARMED)) begin
      errors++; $display("FAIL mid_rel_state: got %0d exp %0d", state, ST_ARMED);
    end
    checks++;
    if ({rise, fall, mismatch} !== 3'b000) begin
      errors++; $display("FAIL mid_rel_pulses: got r=%b f=%b m=%b exp 0", rise, fall, mismatch);
    end
    step(1'b1, 1'b0, 1'b0, M_NORMAL);
    step(1'b1, 1'b0, 1'b0, M_NORMAL);
  endtask

  initial begin
    test_reset();
    test_toggle_run();
    test_single_miss();
    test_saturate();
    test_fault();
    test_clear_in_fault();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
